// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings, latency
// defaults, sequencer states and the 64-bit HI/LO result payload.
package mdu_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic [2:0] MD_MTLO  = 3'b000;
  localparam logic [2:0] MD_MTHI  = 3'b001;
  localparam logic [2:0] MD_MULT  = 3'b010;
  localparam logic [2:0] MD_MULTU = 3'b011;
  localparam logic [2:0] MD_DIV   = 3'b100;
  localparam logic [2:0] MD_DIVU  = 3'b101;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result for mult/multu/div/divu, plus divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output md_result_t      res_o,
  output logic            div_zero_o
);

  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] b_safe;
  logic [2*XLEN-1:0] prod_mag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] q_mag;
  logic [XLEN-1:0] r_mag;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  // Work on magnitudes so signed and unsigned share one multiplier/divider;
  // -2^31 / -1 then wraps to 0x80000000 with no special case.
  assign sgn        = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign a_neg      = sgn & a_i[XLEN-1];
  assign b_neg      = sgn & b_i[XLEN-1];
  assign a_mag      = a_neg ? (~a_i + XLEN'(1)) : a_i;
  assign b_mag      = b_neg ? (~b_i + XLEN'(1)) : b_i;
  assign div_zero_o = (b_i == '0);
  assign b_safe     = div_zero_o ? XLEN'(1) : b_mag;

  assign prod_mag = (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
  assign prod     = (a_neg ^ b_neg) ? (~prod_mag + (2*XLEN)'(1)) : prod_mag;

  assign q_mag = a_mag / b_safe;
  assign r_mag = a_mag % b_safe;
  assign quo   = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
  assign rem   = a_neg ? (~r_mag + XLEN'(1)) : r_mag;

  always_comb begin
    res_o = '0;
    case (op_i)
      MD_MULT, MD_MULTU: res_o = prod;
      MD_DIV, MD_DIVU: begin
        res_o.hi = rem;
        res_o.lo = quo;
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer holding HI/LO with a fixed-latency busy counter.
// Optional abort input enabled by defining MDU_CANCEL_EN.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic            MDWrite,
  input  logic [2:0]      MDOp,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            MDSel,
  input  logic            D_UseMD,
`ifdef MDU_CANCEL_EN
  input  logic            Cancel,
`endif
  output logic            Busy,
  output logic [XLEN-1:0] MDOut,
  output logic            Stall
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  phi_q, phi_d;
  logic [XLEN-1:0]  plo_q, plo_d;
  logic             dz_q, dz_d;
  logic             cancel_c;
  md_result_t       res;
  logic             div_zero;

`ifdef MDU_CANCEL_EN
  assign cancel_c = Cancel;
`else
  assign cancel_c = 1'b0;
`endif

  mdu_arith u_arith (
    .op_i      (MDOp),
    .a_i       (A),
    .b_i       (B),
    .res_o     (res),
    .div_zero_o(div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    dz_d    = dz_q;
    case (state_q)
      MD_IDLE: begin
        if (Start && !cancel_c) begin
          phi_d   = res.hi;
          plo_d   = res.lo;
          dz_d    = div_zero & is_div(MDOp);
          cnt_d   = is_div(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = MD_RUN;
        end else if (MDWrite && !Start) begin
          if (MDOp == MD_MTLO) lo_d = A;
          else if (MDOp == MD_MTHI) hi_d = A;
        end
      end
      MD_RUN: begin
        // New Start/MDWrite are ignored here; the D-stage stall keeps them out.
        if (cancel_c) begin
          cnt_d   = '0;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = MD_IDLE;
            if (!dz_q) begin
              hi_d = phi_q;
              lo_d = plo_q;
            end
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign Busy  = (state_q == MD_RUN);
  assign MDOut = MDSel ? hi_q : lo_q;
  assign Stall = D_UseMD & (Start | Busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected busy length and HI/LO,
// a monitor checks them when each busy period ends.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, Start, MDWrite, MDSel, D_UseMD;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy, Stall;
  logic [31:0] MDOut;
`ifdef MDU_CANCEL_EN
  logic        Cancel;
`endif
  logic        stim_sel, mon_sel, mon_active;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int stall_total = 0;

  typedef struct {
    string       name;
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  assign MDSel = mon_active ? mon_sel : stim_sel;

  mdu_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .MDWrite(MDWrite),
    .MDOp   (MDOp),
    .A      (A),
    .B      (B),
    .MDSel  (MDSel),
    .D_UseMD(D_UseMD),
`ifdef MDU_CANCEL_EN
    .Cancel (Cancel),
`endif
    .Busy   (Busy),
    .MDOut  (MDOut),
    .Stall  (Stall)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles, then reads LO and HI in the first idle cycle.
  initial begin
    int          run;
    exp_t        e;
    logic [31:0] lo_v, hi_v;
    run = 0;
    mon_active = 1'b0;
    mon_sel = 1'b0;
    forever begin
      @(negedge clk);
      if (Busy === 1'b1) run++;
      else if (run > 0) begin
        mon_active = 1'b1;
        mon_sel = 1'b0;
        #1 lo_v = MDOut;
        mon_sel = 1'b1;
        #1 hi_v = MDOut;
        mon_active = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_op: busy run of %0d with no expected entry", run);
        end else begin
          e = sb.pop_front();
          check32({e.name, "_busy"}, 32'(run), 32'(e.n));
          check32({e.name, "_lo"}, lo_v, e.lo);
          check32({e.name, "_hi"}, hi_v, e.hi);
        end
        run = 0;
        done_cnt++;
      end
    end
  end

  // Stall sampled just before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (D_UseMD && Stall) stall_total++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input string name, input int base);
    int t;
    t = 0;
    while (done_cnt == base && t < 500) begin
      #1;
      t++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL %s_timeout: no completion after %0d time units, expected one", name, t);
    end
  endtask

  // mode: 0 plain, 1 write attempt while running, 2 reset in busy cycle 3, 3 cancel in busy cycle 3
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int n, input logic [31:0] hi,
                       input logic [31:0] lo, input int mode);
    int base;
    exp_t e;
    base = done_cnt;
    e.name = name; e.n = n; e.hi = hi; e.lo = lo;
    sb.push_back(e);
    Start = 1'b1; MDWrite = 1'b1; MDOp = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; MDWrite = 1'b0; A = '0; B = '0;
    if (mode == 1) begin
      Start = 1'b1; MDWrite = 1'b1; MDOp = MD_MTHI; A = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      Start = 1'b0; MDWrite = 1'b0; A = '0;
    end else if (mode >= 2) begin
      repeat (2) @(posedge clk);
      #1;
      if (mode == 2) reset = 1'b1;
`ifdef MDU_CANCEL_EN
      else Cancel = 1'b1;
`endif
      @(posedge clk); #1;
      reset = 1'b0;
`ifdef MDU_CANCEL_EN
      Cancel = 1'b0;
`endif
    end
    wait_done(name, base);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] val);
    MDWrite = 1'b1; MDOp = op; A = val;
    @(posedge clk); #1;
    MDWrite = 1'b0; A = '0;
  endtask

  initial begin
    int s0;
    reset = 1'b1; Start = 1'b0; MDWrite = 1'b0; MDOp = '0; A = '0; B = '0;
    D_UseMD = 1'b0; stim_sel = 1'b0;
`ifdef MDU_CANCEL_EN
    Cancel = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check32("rst_busy", 32'(Busy), 32'd0);
    check32("rst_lo", MDOut, 32'h0);
    stim_sel = 1'b1; #1;
    check32("rst_hi", MDOut, 32'h0);
    D_UseMD = 1'b1; Start = 1'b1; #1;
    check32("rst_stall_follows", 32'(Stall), 32'd1);
    Start = 1'b0; #1;
    check32("rst_stall_low", 32'(Stall), 32'd0);
    D_UseMD = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    issue("mult", MD_MULT, 32'hFFFF_FFFF, 32'h2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    issue("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 0);
    D_UseMD = 1'b1;
    s0 = stall_total;
    issue("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'h2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    D_UseMD = 1'b0;
    check32("div_stall_cycles", 32'(stall_total - s0), 32'd11);
    issue("div_7_m2", MD_DIV, 32'h7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    issue("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 0);
    issue("divu_13_4", MD_DIVU, 32'hFFFF_FFF3, 32'h4, 10, 32'h3, 32'h3FFF_FFFC, 0);

    @(posedge clk); #1;
    mt(MD_MTLO, 32'h55);
    stim_sel = 1'b0; #1;
    check32("mtlo_out", MDOut, 32'h55);
    mt(MD_MTHI, 32'hAA);
    stim_sel = 1'b1; #1;
    check32("mthi_out", MDOut, 32'hAA);
    issue("divu_by0", MD_DIVU, 32'h1234, 32'h0, 10, 32'hAA, 32'h55, 0);

    @(posedge clk); #1;
    D_UseMD = 1'b1;
    mt(MD_MTHI, 32'h1234);
    stim_sel = 1'b1; #1;
    check32("mthi_1234", MDOut, 32'h0000_1234);
    check32("mthi_busy", 32'(Busy), 32'd0);
    check32("mthi_stall", 32'(Stall), 32'd0);
    D_UseMD = 1'b0;

    issue("mult_ignore_wr", MD_MULT, 32'h3, 32'h5, 5, 32'h0, 32'hF, 1);
    issue("mult_reset", MD_MULT, 32'h7, 32'h9, 3, 32'h0, 32'h0, 2);
    repeat (10) @(posedge clk);
    #1;
    stim_sel = 1'b0; #1;
    check32("post_reset_lo", MDOut, 32'h0);
    stim_sel = 1'b1; #1;
    check32("post_reset_hi", MDOut, 32'h0);
    check32("post_reset_busy", 32'(Busy), 32'd0);

`ifdef MDU_CANCEL_EN
    mt(MD_MTLO, 32'h11);
    mt(MD_MTHI, 32'h22);
    issue("mult_cancel", MD_MULT, 32'h3, 32'h4, 3, 32'h22, 32'h11, 3);
    @(posedge clk); #1;
    Start = 1'b1; MDWrite = 1'b1; MDOp = MD_MULT; A = 32'h2; B = 32'h3; Cancel = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDWrite = 1'b0; Cancel = 1'b0; A = '0; B = '0;
    check32("start_cancel_busy", 32'(Busy), 32'd0);
    stim_sel = 1'b0; #1;
    check32("start_cancel_lo", MDOut, 32'h11);
`endif

    repeat (20) @(posedge clk);
    #1;
    check32("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
